// File: rtl/button_arbiter.sv
// button_arbiter: accepts one debounced button press at a time, echoes it on led_echo
// and reports its id on release via valid/ready. Define BTN_RR_ARB_EN for round-robin grant.
module button_arbiter #(
  parameter int NUM_BTN  = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_W   = 16,
  parameter int MAX_HOLD = 50000
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [NUM_BTN-1:0] btn_level,
  input  logic               enable,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [NUM_BTN-1:0] led_echo,
  output logic               busy,
  output logic               stuck,
  output logic               multi_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HELD   = 3'd1,
    REPORT = 3'd2,
    STUCK  = 3'd3,
    QUIET  = 3'd4
  } state_e;

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [NUM_BTN-1:0] ONE       = NUM_BTN'(1);

  state_e             state_q, state_d;
  logic [NUM_BTN-1:0] btn_q, btn_d;
  logic [NUM_BTN-1:0] led_q, led_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  logic               evt_valid_q, evt_valid_d;
  logic               stuck_q, stuck_d;
  logic               multi_q, multi_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [NUM_BTN-1:0] rise;
  logic [ID_W-1:0]    pick;
  logic [NUM_BTN-1:0] pick_oh;
  logic               take;

  assign rise    = btn_level & ~btn_q;
  assign take    = (state_q == IDLE) && enable && (|rise);
  assign pick_oh = ONE << pick;

`ifdef BTN_RR_ARB_EN
  logic [ID_W-1:0] last_q, last_d;

  // Scan offsets from farthest to nearest so the nearest rise after last_grant wins.
  always_comb begin
    int unsigned idx;
    pick = '0;
    for (int unsigned i = NUM_BTN; i > 0; i--) begin
      idx = (32'(last_q) + i) % NUM_BTN;
      if (|(rise & (ONE << idx))) pick = ID_W'(idx);
    end
  end

  assign last_d = take ? pick : last_q;

  always_ff @(posedge clk) begin
    if (!n_reset) last_q <= ID_W'(NUM_BTN - 1);
    else          last_q <= last_d;
  end
`else
  always_comb begin
    pick = '0;
    for (int unsigned i = NUM_BTN; i > 0; i--) begin
      if (|(rise & (ONE << (i - 1)))) pick = ID_W'(i - 1);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    btn_d       = btn_level;
    led_d       = led_q;
    grant_d     = grant_q;
    evt_id_d    = evt_id_q;
    evt_valid_d = evt_valid_q;
    stuck_d     = stuck_q;
    multi_d     = 1'b0;
    hold_d      = hold_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          grant_d = pick;
          led_d   = pick_oh;
          hold_d  = '0;
          multi_d = |(rise & (rise - ONE));
          state_d = HELD;
        end
      end
      HELD: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
        multi_d = |(rise & ~led_q);
        // led_q holds the one-hot grant here, so it doubles as the release mask
        if (!(|(btn_level & led_q))) begin
          led_d       = '0;
          evt_id_d    = grant_q;
          evt_valid_d = 1'b1;
          state_d     = REPORT;
        end else if (!enable) begin
          led_d   = '0;
          state_d = QUIET;
        end else if (hold_q == HOLD_LAST) begin
          led_d   = '0;
          stuck_d = 1'b1;
          state_d = STUCK;
        end
      end
      REPORT: begin
        if (evt_valid_q && evt_ready) begin
          evt_valid_d = 1'b0;
          state_d     = QUIET;
        end
      end
      STUCK: begin
        if (btn_level == '0) begin
          stuck_d = 1'b0;
          state_d = IDLE;
        end
      end
      QUIET: begin
        if (btn_level == '0) state_d = IDLE;
      end
      default: begin
        led_d       = '0;
        evt_valid_d = 1'b0;
        stuck_d     = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      btn_q       <= '1;
      led_q       <= '0;
      grant_q     <= '0;
      evt_id_q    <= '0;
      evt_valid_q <= 1'b0;
      stuck_q     <= 1'b0;
      multi_q     <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_d;
      led_q       <= led_d;
      grant_q     <= grant_d;
      evt_id_q    <= evt_id_d;
      evt_valid_q <= evt_valid_d;
      stuck_q     <= stuck_d;
      multi_q     <= multi_d;
      hold_q      <= hold_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign led_echo  = led_q;
  assign busy      = (state_q != IDLE);
  assign stuck     = stuck_q;
  assign multi_err = multi_q;

endmodule

// File: tb/tb_button_arbiter.sv
// Directed bench for button_arbiter with MAX_HOLD=8; expected grant order follows BTN_RR_ARB_EN.
module tb_button_arbiter;

  logic       clk;
  logic       n_reset;
  logic [3:0] btn_level;
  logic       enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] led_echo;
  logic       busy;
  logic       stuck;
  logic       multi_err;

  int unsigned n_checks;
  int unsigned n_pass;

`ifdef BTN_RR_ARB_EN
  localparam logic [1:0] SECOND_ID  = 2'd3;
  localparam logic [3:0] SECOND_LED = 4'b1000;
`else
  localparam logic [1:0] SECOND_ID  = 2'd1;
  localparam logic [3:0] SECOND_LED = 4'b0010;
`endif

  button_arbiter #(
    .NUM_BTN (4),
    .ID_W    (2),
    .HOLD_W  (16),
    .MAX_HOLD(8)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .btn_level(btn_level),
    .enable   (enable),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .led_echo (led_echo),
    .busy     (busy),
    .stuck    (stuck),
    .multi_err(multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {evt_valid, evt_id, led_echo, busy, stuck, multi_err}
  function automatic logic [31:0] outs();
    return {22'd0, evt_valid, evt_id, led_echo, busy, stuck, multi_err};
  endfunction

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    n_reset   = 1'b0;
    btn_level = 4'b0000;
    enable    = 1'b0;
    evt_ready = 1'b0;
    step();
    step();
    check_eq("reset_outs", outs(), 32'd0);
    n_reset = 1'b1;
    step();
    check_eq("idle_after_reset", outs(), 32'd0);

    // Simultaneous press: lowest index first after reset in both modes
    enable    = 1'b1;
    btn_level = 4'b1010;
    step();
    check_eq("multi_led", led_echo, 4'b0010);
    check_eq("multi_err_pulse", multi_err, 1'b1);
    step();
    check_eq("multi_err_once", multi_err, 1'b0);
    btn_level = 4'b0000;
    step();
    check_eq("multi_valid", evt_valid, 1'b1);
    check_eq("multi_id", evt_id, 2'd1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    step();
    check_eq("multi_idle", busy, 1'b0);
    btn_level = 4'b1010;
    step();
    check_eq("multi2_led", led_echo, SECOND_LED);
    check_eq("multi2_err", multi_err, 1'b1);
    btn_level = 4'b0000;
    step();
    check_eq("multi2_id", evt_id, SECOND_ID);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    step();

    // Single press of button 2 held for three cycles
    btn_level = 4'b0100;
    step();
    check_eq("single_led0", led_echo, 4'b0100);
    check_eq("single_busy", busy, 1'b1);
    step();
    step();
    check_eq("single_led2", led_echo, 4'b0100);
    check_eq("single_novalid", evt_valid, 1'b0);
    btn_level = 4'b0000;
    step();
    check_eq("single_valid", evt_valid, 1'b1);
    check_eq("single_id", evt_id, 2'd2);
    check_eq("single_led_off", led_echo, 4'b0000);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check_eq("single_ack", evt_valid, 1'b0);
    check_eq("single_quiet_busy", busy, 1'b1);
    step();
    check_eq("single_idle", busy, 1'b0);

    // Backpressure, with a press of button 0 that must not be granted early
    btn_level = 4'b0100;
    step();
    step();
    btn_level = 4'b0000;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) btn_level = 4'b0001;
      step();
      check_eq("bp_valid", evt_valid, 1'b1);
      check_eq("bp_id", evt_id, 2'd2);
      check_eq("bp_no_grant", led_echo, 4'b0000);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check_eq("bp_ack", evt_valid, 1'b0);
    step();
    step();
    check_eq("bp_quiet_busy", busy, 1'b1);
    check_eq("bp_quiet_led", led_echo, 4'b0000);
    btn_level = 4'b0000;
    step();
    check_eq("bp_idle", busy, 1'b0);
    btn_level = 4'b0001;
    step();
    check_eq("bp_new_grant", led_echo, 4'b0001);
    btn_level = 4'b0000;
    step();
    check_eq("bp_new_id", evt_id, 2'd0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    step();

    // Stuck: button 3 held for 20 cycles
    btn_level = 4'b1000;
    step();
    check_eq("stuck_grant", led_echo, 4'b1000);
    for (int i = 1; i < 8; i++) begin
      step();
      check_eq("stuck_not_yet", stuck, 1'b0);
    end
    check_eq("stuck_led_last_held", led_echo, 4'b1000);
    step();
    check_eq("stuck_set", stuck, 1'b1);
    check_eq("stuck_led_off", led_echo, 4'b0000);
    check_eq("stuck_busy", busy, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step();
      check_eq("stuck_hold", {evt_valid, stuck}, 2'b01);
    end
    btn_level = 4'b0000;
    step();
    check_eq("stuck_release", {busy, stuck, evt_valid}, 3'b000);

    // Enable handling
    enable    = 1'b0;
    btn_level = 4'b0011;
    step();
    check_eq("dis_no_grant", {busy, led_echo, multi_err}, 6'd0);
    btn_level = 4'b0000;
    step();
    enable    = 1'b1;
    btn_level = 4'b0010;
    step();
    check_eq("abort_grant", led_echo, 4'b0010);
    step();
    enable = 1'b0;
    step();
    check_eq("abort_led", led_echo, 4'b0000);
    check_eq("abort_novalid", evt_valid, 1'b0);
    step();
    check_eq("abort_quiet", busy, 1'b1);
    btn_level = 4'b0000;
    step();
    check_eq("abort_idle", {busy, evt_valid}, 2'b00);
    enable    = 1'b1;
    btn_level = 4'b0100;
    step();
    btn_level = 4'b0000;
    step();
    enable = 1'b0;
    step();
    check_eq("rep_dis_valid", evt_valid, 1'b1);
    check_eq("rep_dis_id", evt_id, 2'd2);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check_eq("rep_dis_ack", evt_valid, 1'b0);
    step();

    // Reset during REPORT with button 1 held
    enable    = 1'b1;
    btn_level = 4'b0010;
    step();
    btn_level = 4'b0000;
    step();
    check_eq("rst_pre_valid", evt_valid, 1'b1);
    btn_level = 4'b0010;
    step();
    n_reset = 1'b0;
    step();
    check_eq("rst_outs", outs(), 32'd0);
    n_reset = 1'b1;
    step();
    check_eq("rst_held_no_grant", {busy, led_echo}, 5'd0);
    step();
    check_eq("rst_held_no_grant2", {busy, led_echo}, 5'd0);
    btn_level = 4'b0000;
    step();
    btn_level = 4'b0010;
    step();
    check_eq("rst_repress_grant", led_echo, 4'b0010);
    check_eq("rst_repress_busy", busy, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_arbiter.md
Name: button_arbiter

Overview:
Sits between the per-button debouncers and the Simon game FSM. Takes NUM_BTN debounced button levels and accepts exactly one press at a time. Lights an echo LED while the press is held and reports the button id to the game FSM on release through a valid/ready handshake. Also handles simultaneous presses, presses while disabled, and stuck buttons.

Parameters:
NUM_BTN, 4, number of buttons (2..8)
ID_W, 2, width of evt_id; must equal clog2(NUM_BTN)
HOLD_W, 16, width of hold-time counter
MAX_HOLD, 50000, cycles a press may be held before it is declared stuck (1 s at 50 kHz); must be < 2^HOLD_W

Ports:
clk  in  1  clock
n_reset  in  1  reset; synchronous, active-low
btn_level  in  NUM_BTN  debounced button levels, 1 = pressed
enable  in  1  game FSM is in the player-input phase
evt_valid  out  1  release event pending
evt_ready  in  1  game FSM accepts the event
evt_id  out  ID_W  index of released button; stable while evt_valid
led_echo  out  NUM_BTN  one-hot echo of the granted button while held
busy  out  1  high in any state other than IDLE
stuck  out  1  high while in STUCK
multi_err  out  1  one-cycle pulse on a rejected concurrent press

Behaviour:
- Reset (n_reset=0 at clk edge):
  - state=IDLE; evt_valid=0, evt_id=0, led_echo=0, stuck=0, multi_err=0, hold counter=0.
  - btn_q set to all ones, so a button held through reset gives no rise.
  - Reset mid-operation discards any pending event.
- Edge detect: btn_q <= btn_level every cycle; rise = btn_level & ~btn_q.
- IDLE:
  - if enable && |rise: grant one bit of rise, capture grant index, led_echo <= onehot(grant), hold counter <= 0, go HELD.
  - multi_err <= 1 if popcount(rise) > 1.
  - if !enable: rises are ignored, no error.
- HELD (led_echo stays asserted, hold counter +1 per cycle):
  - btn_level[grant]==0: led_echo <= 0, evt_id <= grant, evt_valid <= 1, go REPORT. evt_valid is high on the edge after release is sampled.
  - else if !enable: abort, led_echo <= 0, go QUIET, no event.
  - else if counter==MAX_HOLD-1: led_echo <= 0, go STUCK.
  - a rise on any other button pulses multi_err and is otherwise ignored.
- REPORT:
  - evt_valid and evt_id held stable until evt_valid && evt_ready at an edge.
  - on that edge: evt_valid <= 0, go QUIET.
  - enable is ignored here; an accepted press is always delivered.
- STUCK: stuck=1; when btn_level==0, go IDLE with stuck <= 0; no event is emitted.
- QUIET: go IDLE once btn_level==0 is sampled. This blocks new grants until every button is released.
- At most one event is outstanding; no buffering beyond evt_id.
- Counter saturates; it never wraps.
- State encoding: 3-bit, illegal values recover to IDLE.

Optional Feature:
BTN_RR_ARB_EN
- Defined: round-robin grant among simultaneous rises.
  - search starts at (last_grant+1) mod NUM_BTN.
  - last_grant updates on each grant; it resets to NUM_BTN-1, so index 0 is first priority after reset.
- Undefined: fixed priority, lowest index wins; no last_grant register.

Test Plan:
- Single press with MAX_HOLD=8: enable=1, btn_level 0000->0100, held 3 cycles, then 0000.
  - Required: led_echo=0100 while held; evt_valid=1 with evt_id=2 on the edge after release sampled; ready=1 clears it next cycle; busy=0 two cycles later.
- Simultaneous press: btn_level 0000->1010.
  - Required: multi_err pulses once, grant id=1 (fixed priority); after release and ack, a second 1010 press grants id=1 again (fixed) or id=3 (BTN_RR_ARB_EN).
- Backpressure: evt_ready=0 for 10 cycles after release.
  - Required: evt_valid and evt_id=2 stay stable.
  - Required: a new press of btn 0 during REPORT/QUIET is not granted until all buttons read 0 and state is back in IDLE.
- Stuck: MAX_HOLD=8, btn 3 held 20 cycles.
  - Required: STUCK entered after 8 cycles in HELD, stuck=1, led_echo=0, no evt_valid.
  - Required: release returns to IDLE with stuck=0.
- Enable handling: press with enable=0 -> no grant, busy=0. Press with enable=1, then drop enable mid-hold -> abort, no event. Drop enable in REPORT -> event still delivered.
- Reset: assert n_reset=0 during REPORT with btn 1 held.
  - Required: all outputs 0.
  - Required: after reset deasserts with btn 1 still held, no grant occurs until btn 1 is released and pressed again.
